// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its buffer.
package fetch_sequencer_pkg;

    localparam int PC_WIDTH          = 8;
    localparam int INSTRUCTION_WIDTH = 16;
    localparam int FETCH_BUF_DEPTH   = 2;
    localparam int FETCH_CNT_WIDTH   = $clog2(FETCH_BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_WIDTH-1:0]          pc;
        logic [INSTRUCTION_WIDTH-1:0] instruction;
    } fetch_entry_t;

    function automatic logic pc_is_legal(input logic [PC_WIDTH-1:0] pc, input int depth);
        return int'(pc) < depth;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO between fetch and decode; accepts a push while full if the head pops in the same cycle.
module fetch_skid_buffer
    import fetch_sequencer_pkg::*;
(
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  fetch_entry_t               push_entry_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [FETCH_CNT_WIDTH-1:0] count_o,
    output logic                       head_valid_o,
    output fetch_entry_t               head_o
);

    logic [FETCH_CNT_WIDTH-1:0] count_q, count_d;
    fetch_entry_t               mem_q [FETCH_BUF_DEPTH];
    fetch_entry_t               mem_d [FETCH_BUF_DEPTH];
    logic                       do_pop;
    logic                       do_push;
    logic                       wr_idx;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q < FETCH_CNT_WIDTH'(FETCH_BUF_DEPTH)) || do_pop);
    // After a same-cycle pop the write slot moves down by one.
    assign wr_idx  = do_pop ? count_q[1] : count_q[0];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (do_pop) begin
                mem_d[0] = mem_q[1];
            end
            if (do_push) begin
                mem_d[wr_idx] = push_entry_i;
            end
            count_d = count_q + FETCH_CNT_WIDTH'(do_push) - FETCH_CNT_WIDTH'(do_pop);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_o       = mem_q[0];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, buffers fetched words for decode,
// and handles redirects, end-of-image halt and sticky fetch errors.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int MEM_DEPTH = 12,
    parameter int RESET_PC  = 0,
    parameter int WRAP_EN   = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    output logic [PC_WIDTH-1:0]          mem_pc,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_instruction,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
    output logic [PC_WIDTH-1:0]          out_pc,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    output logic                         busy,
    output logic                         halted,
    output logic                         fetch_error,
    output fetch_state_t                 dbg_state
);

    // Handshake: a word moves to decode on any cycle where out_valid && out_ready,
    // except a redirect cycle, which discards the buffer instead.

    localparam logic [PC_WIDTH-1:0] LAST_PC  = PC_WIDTH'(MEM_DEPTH - 1);
    localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(RESET_PC);
    localparam logic                WRAP     = (WRAP_EN != 0);

    fetch_state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic                       err_q, err_d;
    logic [FETCH_CNT_WIDTH-1:0] buf_count;
    logic                       buf_valid;
    fetch_entry_t               buf_head;
    fetch_entry_t               push_entry;
    logic                       redirect_legal;
    logic                       pop;
    logic                       push_fire;
    logic                       last_fetch;

    assign redirect_legal = redirect_valid && pc_is_legal(redirect_pc, MEM_DEPTH);
    assign pop            = buf_valid && out_ready && !redirect_valid;
    assign push_fire      = (state_q == FETCH) && !redirect_valid &&
                            ((buf_count < FETCH_CNT_WIDTH'(FETCH_BUF_DEPTH)) || pop);
    assign last_fetch     = (pc_q == LAST_PC);
    assign push_entry     = '{pc: pc_q, instruction: mem_instruction};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = redirect_legal ? FETCH : HALTED;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = FETCH;
                FETCH:   if (push_fire && last_fetch && !WRAP) state_d = HALTED;
                HALTED:  state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q == FETCH);
        halted = (state_q == HALTED);
    end

    always_comb begin
        pc_d  = pc_q;
        err_d = err_q || (redirect_valid && !redirect_legal);
        if (redirect_legal) begin
            pc_d = redirect_pc;
        end else if (push_fire) begin
            // Without wrap the PC parks on the last word once it has been fetched.
            if (last_fetch) begin
                pc_d = WRAP ? '0 : pc_q;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= START_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    fetch_skid_buffer u_buffer (
        .clock_i      (clock),
        .reset_i      (reset),
        .push_i       (push_fire),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (buf_count),
        .head_valid_o (buf_valid),
        .head_o       (buf_head)
    );

    assign mem_pc          = pc_q;
    assign out_valid       = buf_valid;
    assign out_instruction = buf_head.instruction;
    assign out_pc          = buf_head.pc;
    assign fetch_error     = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized ready/redirect run
// checked against an expected-PC stream model.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int DEPTH = 12;

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         start, out_ready, redirect_valid;
    logic [PC_WIDTH-1:0]          redirect_pc;
    logic [PC_WIDTH-1:0]          mem_pc, out_pc;
    logic [INSTRUCTION_WIDTH-1:0] mem_instruction, out_instruction;
    logic                         out_valid, busy, halted, fetch_error;
    fetch_state_t                 dbg_state;

    logic                         w_start, w_ready, w_redirect_valid;
    logic [PC_WIDTH-1:0]          w_redirect_pc;
    logic [PC_WIDTH-1:0]          w_mem_pc, w_out_pc;
    logic [INSTRUCTION_WIDTH-1:0] w_mem_instruction, w_out_instruction;
    logic                         w_out_valid, w_busy, w_halted, w_fetch_error;
    fetch_state_t                 w_dbg_state;

    int                  vectors = 0;
    int                  miscompares = 0;
    logic [PC_WIDTH-1:0] exp_q[$];
    bit                  model_idle, model_err;
    int                  w_exp, w_pops;

    always #5 clock = ~clock;

    assign mem_instruction   = 16'h1000 + 16'(mem_pc);
    assign w_mem_instruction = 16'h1000 + 16'(w_mem_pc);

    fetch_sequencer #(.MEM_DEPTH(DEPTH), .RESET_PC(0), .WRAP_EN(0)) dut (
        .clock(clock), .reset(reset), .start(start),
        .mem_pc(mem_pc), .mem_instruction(mem_instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .halted(halted), .fetch_error(fetch_error),
        .dbg_state(dbg_state)
    );

    fetch_sequencer #(.MEM_DEPTH(DEPTH), .RESET_PC(0), .WRAP_EN(1)) dut_wrap (
        .clock(clock), .reset(reset), .start(w_start),
        .mem_pc(w_mem_pc), .mem_instruction(w_mem_instruction),
        .out_valid(w_out_valid), .out_ready(w_ready),
        .out_instruction(w_out_instruction), .out_pc(w_out_pc),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .busy(w_busy), .halted(w_halted), .fetch_error(w_fetch_error),
        .dbg_state(w_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_idle = 1'b1;
        model_err  = 1'b0;
        w_exp      = 0;
        w_pops     = 0;
    endtask

    task automatic fill(input int from_pc);
        for (int k = from_pc; k < DEPTH; k++) exp_q.push_back(PC_WIDTH'(k));
    endtask

    // Scores this cycle's handshakes and updates the model, then advances one clock.
    task automatic cycle();
        logic [PC_WIDTH-1:0] e;
        if (!reset) begin
            if (out_valid && out_ready && !redirect_valid) begin
                vectors++;
                assert (exp_q.size() > 0) else begin
                    miscompares++;
                    $error("FAIL extra_pop: observed pc %0d, expected no further pop", out_pc);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pop_pc", out_pc, e);
                    check("pop_instr", out_instruction, 16'h1000 + 16'(e));
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                if (int'(redirect_pc) < DEPTH) fill(int'(redirect_pc));
                else model_err = 1'b1;
                model_idle = 1'b0;
            end else if (start && model_idle) begin
                fill(0);
                model_idle = 1'b0;
            end
            if (w_out_valid && w_ready) begin
                check("wrap_pc", w_out_pc, w_exp);
                check("wrap_instr", w_out_instruction, 16'h1000 + 16'(w_exp));
                w_exp = (w_exp + 1) % DEPTH;
                w_pops++;
            end
        end
        @(posedge clock);
        #1;
        start          = 1'b0;
        redirect_valid = 1'b0;
        w_start        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while (!(!out_valid && halted) && n < max) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, {30'd0, out_valid, halted}, 32'd1);
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        w_start = 1'b0; w_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instruction, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_mem_pc", mem_pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_fetch_error", fetch_error, 0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b0;

        // Straight run to the end of the image.
        out_ready = 1'b1;
        cycle();
        start = 1'b1;
        cycle();
        check("lat_n1_valid", out_valid, 0);
        check("lat_n1_busy", busy, 1);
        cycle();
        check("lat_n2_valid", out_valid, 1);
        check("lat_n2_pc", out_pc, 0);
        check("lat_n2_instr", out_instruction, 16'h1000);
        drain("run", 40);
        check("run_halted", halted, 1);

        // Backpressure fills both entries and stalls the PC.
        do_reset();
        out_ready = 1'b0;
        start = 1'b1;
        cycle();
        repeat (5) cycle();
        check("stall_mem_pc", mem_pc, 2);
        check("stall_head_pc", out_pc, 0);
        check("stall_valid", out_valid, 1);
        check("stall_busy", busy, 1);
        out_ready = 1'b1;
        drain("stall", 40);

        // Legal redirect while pc 3 is at the head.
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            if (out_valid && out_pc == 3) break;
            cycle();
        end
        check("rd_head3", out_pc, 3);
        redirect_valid = 1'b1;
        redirect_pc = 8;
        cycle();
        check("rd_n1_valid", out_valid, 0);
        cycle();
        check("rd_n2_valid", out_valid, 1);
        check("rd_n2_pc", out_pc, 8);
        check("rd_n2_instr", out_instruction, 16'h1008);
        drain("rd", 40);

        // Illegal redirect, then recovery with a legal one.
        do_reset();
        start = 1'b1;
        cycle();
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc = 12;
        cycle();
        check("ill_err", fetch_error, 1);
        check("ill_halted", halted, 1);
        check("ill_valid", out_valid, 0);
        repeat (3) cycle();
        check("ill_still_halted", halted, 1);
        check("ill_still_empty", out_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 0;
        cycle();
        check("rec_busy", busy, 1);
        check("rec_err_sticky", fetch_error, 1);
        cycle();
        check("rec_head_pc", out_pc, 0);
        drain("rec", 40);
        check("rec_err_end", fetch_error, 1);

        // Randomized ready and redirects, including illegal targets.
        do_reset();
        start = 1'b1;
        cycle();
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = PC_WIDTH'($urandom_range(0, 13));
            end
            cycle();
            check("rnd_err", fetch_error, model_err);
        end
        out_ready = 1'b1;
        drain("rnd", 40);

        // Wrap-enabled instance runs past the last word.
        w_start = 1'b1;
        cycle();
        for (int i = 0; i < 25; i++) begin
            cycle();
            check("wrap_not_halted", w_halted, 0);
        end
        check("wrap_pop_count", w_pops, 24);

        // Asynchronous reset between edges while both instances stream.
        do_reset();
        out_ready = 1'b1;
        start = 1'b1;
        w_start = 1'b1;
        cycle();
        repeat (4) cycle();
        check("ar_pre_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_pc", out_pc, 0);
        check("ar_out_instr", out_instruction, 0);
        check("ar_mem_pc", mem_pc, 0);
        check("ar_busy", busy, 0);
        check("ar_wrap_valid", w_out_valid, 0);
        check("ar_wrap_mem_pc", w_mem_pc, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        start = 1'b1;
        cycle();
        cycle();
        check("ar_restart_valid", out_valid, 1);
        check("ar_restart_pc", out_pc, 0);
        check("ar_restart_instr", out_instruction, 16'h1000);
        drain("ar", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
